pong_engine: RTL and testbench
==============================

# pong_engine

Parametrised game-logic core for the LED-matrix pong: owns the ball, two paddles, scores and the match state machine, all advanced by an internal game tick. Generalises the free-running bouncing ball to a configurable board size, player-controlled paddles, miss detection, scoring and game-over. Sits between the button inputs and the screen driver, which consumes `ball_x`/`ball_y`/paddle rows.

## Interface
- `COLS`, 16, board width; paddles in columns 0 and COLS-1 (min 4)
- `ROWS`, 16, board height (min 4)
- `PADDLE_LEN`, 4, paddle height in rows (1..ROWS)
- `TICK_DIV`, 6000, clk cycles per game tick (≥1)
- `BALL_PERIOD`, 20, game ticks per ball step (≥1)
- `PADDLE_PERIOD`, 50, game ticks per paddle step (≥1)
- `SCORE_MAX`, 9, points that win a match (1..15)

- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  level; starts a match from IDLE or OVER
- `l_up`, `l_down`, `r_up`, `r_down`  in  1 each  paddle buttons, synchronous to clk
- `ball_x`  out  $clog2(COLS)  ball column
- `ball_y`  out  $clog2(ROWS)  ball row
- `paddle_l`, `paddle_r`  out  $clog2(ROWS)  top row of each paddle
- `score_l`, `score_r`  out  4  scores
- `state`  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3
- `winner`  out  1  0=left, 1=right; valid in OVER
- `point`  out  1  one-cycle pulse when a point is scored

## Operation
- Reset values: state IDLE, ball (COLS/2, ROWS/2), dx=+1, dy=+1, paddles (ROWS-PADDLE_LEN)/2, scores 0, winner 0, point 0, all counters 0.
- IDLE: start=1 → SERVE. OVER: start=1 → scores cleared, SERVE.
- SERVE: ball held at centre; after BALL_PERIOD ticks → PLAY.
- PLAY, on each ball step, in order:
  - vertical: if y+dy leaves [0,ROWS-1], negate dy first; y ← y+dy.
  - horizontal at x==1 with dx=-1: hit if new y ∈ [paddle_l, paddle_l+PADDLE_LEN-1] → dx=+1, x=2; else miss → score_r+1. Mirror at x==COLS-2 with dx=+1 against paddle_r (hit → x=COLS-3; miss → score_l+1).
  - otherwise x ← x+dx.
- Miss: point=1 for one cycle; ball to centre; dx set toward the player who conceded; dy unchanged. If incremented score == SCORE_MAX → OVER, winner = scorer; else → SERVE.
- Paddles, every PADDLE_PERIOD ticks, all states except OVER: up&&!down and row>0 → row-1; down&&!up and row<ROWS-PADDLE_LEN → row+1; both or neither → hold.
- Collision uses paddle values registered before the current tick; a paddle step on the same tick takes effect next step.

## Timing
- Game tick: one-cycle pulse every TICK_DIV clk cycles, free-running from reset.
- Ball counter counts ticks 0..BALL_PERIOD-1; step occurs on the tick where it equals BALL_PERIOD-1; outputs change on the following clk edge. Counter clears on entry to SERVE.
- Paddle counter identical with PADDLE_PERIOD; never cleared except by reset.
- start is sampled every clk, not only on ticks; state changes the next edge.
- `point` asserts on the same edge that scores update; state enters SERVE/OVER on that edge.
- reset_n low mid-match: all registers return to reset values asynchronously; no point pulse.

## Configuration
- `PONG_AI_EN` defined: r_up/r_down ignored; right paddle moves up if ball_y < paddle_r, down if ball_y > paddle_r+PADDLE_LEN-1, on the paddle period, same limits.
- Not defined: right paddle driven by r_up/r_down exactly as the left.

## Structure
- `pong_pkg`: state enum type, STATE_IDLE/SERVE/PLAY/OVER constants, score width constant.
- Sub-module `game_tick` (parameter TICK_DIV; clk, reset_n → tick pulse); everything else in pong_engine.

## Test plan
Bench uses COLS=8, ROWS=8, PADDLE_LEN=2, TICK_DIV=2, BALL_PERIOD=1, PADDLE_PERIOD=1, SCORE_MAX=2.
- Reset → ball (4,4), paddles 3, scores 0, state 0, point 0.
- start 1 cycle, no buttons → SERVE for 1 tick then PLAY; first step ball (5,5).
- Ball reaches y=7 with dy=+1 → next step y=6, dy=-1.
- Ball at x=6, dx=+1, y=4, paddle_r=3 → hit, x=5, dx=-1, no point.
- Ball at x=6, paddle_r=0 → point pulse, score_l=1, ball (4,4), state SERVE; second miss → score_l=2, state OVER, winner=0; start → scores 0, SERVE.
- l_up and l_down both held 5 ticks → paddle_l unchanged; l_up held 5 ticks → paddle_l=0, no underflow; with PONG_AI_EN, ball_y=7 → paddle_r climbs to 6.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game core: match states and score width.
package pong_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_SERVE = 2'd1,
    STATE_PLAY  = 2'd2,
    STATE_OVER  = 2'd3
  } state_e;

  localparam int SCORE_W = 4;

endpackage

// File: rtl/game_tick.sv
// Free-running game tick: one-cycle pulse every TICK_DIV clk cycles, phase set by reset.
module game_tick #(
  parameter int TICK_DIV = 6000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pong_engine.sv
// Pong game core: ball, paddles, scores and match FSM, advanced by an internal game tick.
// Define PONG_AI_EN to have the right paddle track the ball instead of r_up/r_down.
module pong_engine
  import pong_pkg::*;
#(
  parameter int COLS          = 16,
  parameter int ROWS          = 16,
  parameter int PADDLE_LEN    = 4,
  parameter int TICK_DIV      = 6000,
  parameter int BALL_PERIOD   = 20,
  parameter int PADDLE_PERIOD = 50,
  parameter int SCORE_MAX     = 9
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     l_up,
  input  logic                     l_down,
  input  logic                     r_up,
  input  logic                     r_down,
  output logic [$clog2(COLS)-1:0]  ball_x,
  output logic [$clog2(ROWS)-1:0]  ball_y,
  output logic [$clog2(ROWS)-1:0]  paddle_l,
  output logic [$clog2(ROWS)-1:0]  paddle_r,
  output logic [SCORE_W-1:0]       score_l,
  output logic [SCORE_W-1:0]       score_r,
  output logic [1:0]               state,
  output logic                     winner,
  output logic                     point
);

  localparam int XW   = $clog2(COLS);
  localparam int YW   = $clog2(ROWS);
  localparam int BC_W = (BALL_PERIOD > 1) ? $clog2(BALL_PERIOD) : 1;
  localparam int PC_W = (PADDLE_PERIOD > 1) ? $clog2(PADDLE_PERIOD) : 1;

  localparam logic [XW-1:0]      X_C      = XW'(COLS / 2);
  localparam logic [XW-1:0]      X_ONE    = XW'(1);
  localparam logic [XW-1:0]      X_TWO    = XW'(2);
  localparam logic [XW-1:0]      X_NEAR_R = XW'(COLS - 2);
  localparam logic [XW-1:0]      X_BNC_R  = XW'(COLS - 3);
  localparam logic [YW-1:0]      Y_C      = YW'(ROWS / 2);
  localparam logic [YW-1:0]      Y_MAX    = YW'(ROWS - 1);
  localparam logic [YW-1:0]      P_INIT   = YW'((ROWS - PADDLE_LEN) / 2);
  localparam logic [YW-1:0]      P_MAX    = YW'(ROWS - PADDLE_LEN);
  localparam logic [YW:0]        PLM1     = (YW+1)'(PADDLE_LEN - 1);
  localparam logic [BC_W-1:0]    BC_LAST  = BC_W'(BALL_PERIOD - 1);
  localparam logic [PC_W-1:0]    PC_LAST  = PC_W'(PADDLE_PERIOD - 1);
  localparam logic [SCORE_W-1:0] SMAX     = SCORE_W'(SCORE_MAX);

  logic tick;

  game_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  state_e             state_q, state_d;
  logic [XW-1:0]      ball_x_q, ball_x_d;
  logic [YW-1:0]      ball_y_q, ball_y_d;
  logic               dx_neg_q, dx_neg_d;
  logic               dy_neg_q, dy_neg_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic               winner_q, winner_d;
  logic               point_q, point_d;
  logic [BC_W-1:0]    ball_cnt_q, ball_cnt_d;
  logic [PC_W-1:0]    pad_cnt_q, pad_cnt_d;
  logic [YW-1:0]      paddle_q [2];
  logic [YW-1:0]      paddle_d [2];

  logic ball_step, paddle_step;
  assign ball_step   = tick && (ball_cnt_q == BC_LAST);
  assign paddle_step = tick && (pad_cnt_q == PC_LAST);
  assign pad_cnt_d   = tick ? ((pad_cnt_q == PC_LAST) ? '0 : pad_cnt_q + PC_W'(1)) : pad_cnt_q;

  function automatic logic [YW-1:0] step_paddle(input logic [YW-1:0] row,
                                                input logic up, input logic dn);
    if (up && !dn && row != '0)   return row - YW'(1);
    if (dn && !up && row < P_MAX) return row + YW'(1);
    return row;
  endfunction

  // Index 0 is the left paddle, index 1 the right one.
  logic [1:0] btn_up, btn_dn;
  assign btn_up[0] = l_up;
  assign btn_dn[0] = l_down;
`ifdef PONG_AI_EN
  logic unused_r_btns;
  assign unused_r_btns = r_up ^ r_down;
  assign btn_up[1] = (ball_y_q < paddle_q[1]);
  assign btn_dn[1] = ({1'b0, ball_y_q} > ({1'b0, paddle_q[1]} + PLM1));
`else
  assign btn_up[1] = r_up;
  assign btn_dn[1] = r_down;
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_paddle
    assign paddle_d[gi] = (paddle_step && state_q != STATE_OVER)
                        ? step_paddle(paddle_q[gi], btn_up[gi], btn_dn[gi])
                        : paddle_q[gi];
  end

  // Vertical move with wall bounce; dy flips before the ball moves.
  logic [YW-1:0] ny;
  logic          dy_neg_n;
  always_comb begin
    dy_neg_n = dy_neg_q;
    ny       = ball_y_q;
    if (!dy_neg_q) begin
      if (ball_y_q == Y_MAX) begin
        dy_neg_n = 1'b1;
        ny       = ball_y_q - YW'(1);
      end else begin
        ny = ball_y_q + YW'(1);
      end
    end else begin
      if (ball_y_q == '0) begin
        dy_neg_n = 1'b0;
        ny       = ball_y_q + YW'(1);
      end else begin
        ny = ball_y_q - YW'(1);
      end
    end
  end

  logic hit_l, hit_r;
  assign hit_l = ({1'b0, ny} >= {1'b0, paddle_q[0]}) &&
                 ({1'b0, ny} <= ({1'b0, paddle_q[0]} + PLM1));
  assign hit_r = ({1'b0, ny} >= {1'b0, paddle_q[1]}) &&
                 ({1'b0, ny} <= ({1'b0, paddle_q[1]} + PLM1));

  always_comb begin
    logic               miss_l, miss_r;
    logic [SCORE_W-1:0] new_score;
    state_d    = state_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    dx_neg_d   = dx_neg_q;
    dy_neg_d   = dy_neg_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    winner_d   = winner_q;
    point_d    = 1'b0;
    miss_l     = 1'b0;
    miss_r     = 1'b0;
    new_score  = '0;
    ball_cnt_d = tick ? ((ball_cnt_q == BC_LAST) ? '0 : ball_cnt_q + BC_W'(1)) : ball_cnt_q;

    case (state_q)
      STATE_IDLE: begin
        if (start) begin
          state_d    = STATE_SERVE;
          ball_cnt_d = '0;
        end
      end
      STATE_SERVE: begin
        if (ball_step) state_d = STATE_PLAY;
      end
      STATE_PLAY: begin
        if (ball_step) begin
          ball_y_d = ny;
          dy_neg_d = dy_neg_n;
          if (ball_x_q == X_ONE && dx_neg_q) begin
            if (hit_l) begin
              dx_neg_d = 1'b0;
              ball_x_d = X_TWO;
            end else begin
              miss_l = 1'b1;
            end
          end else if (ball_x_q == X_NEAR_R && !dx_neg_q) begin
            if (hit_r) begin
              dx_neg_d = 1'b1;
              ball_x_d = X_BNC_R;
            end else begin
              miss_r = 1'b1;
            end
          end else begin
            ball_x_d = dx_neg_q ? ball_x_q - XW'(1) : ball_x_q + XW'(1);
          end

          // The serve heads back toward whoever conceded; dy keeps its post-bounce value.
          if (miss_l || miss_r) begin
            point_d   = 1'b1;
            ball_x_d  = X_C;
            ball_y_d  = Y_C;
            dx_neg_d  = miss_l;
            new_score = miss_l ? score_r_q + SCORE_W'(1) : score_l_q + SCORE_W'(1);
            if (miss_l) score_r_d = new_score;
            else        score_l_d = new_score;
            if (new_score == SMAX) begin
              state_d  = STATE_OVER;
              winner_d = miss_l;
            end else begin
              state_d    = STATE_SERVE;
              ball_cnt_d = '0;
            end
          end
        end
      end
      STATE_OVER: begin
        if (start) begin
          score_l_d  = '0;
          score_r_d  = '0;
          state_d    = STATE_SERVE;
          ball_cnt_d = '0;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= STATE_IDLE;
      ball_x_q    <= X_C;
      ball_y_q    <= Y_C;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      winner_q    <= 1'b0;
      point_q     <= 1'b0;
      ball_cnt_q  <= '0;
      pad_cnt_q   <= '0;
      paddle_q[0] <= P_INIT;
      paddle_q[1] <= P_INIT;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
      point_q     <= point_d;
      ball_cnt_q  <= ball_cnt_d;
      pad_cnt_q   <= pad_cnt_d;
      paddle_q[0] <= paddle_d[0];
      paddle_q[1] <= paddle_d[1];
    end
  end

  assign ball_x   = ball_x_q;
  assign ball_y   = ball_y_q;
  assign paddle_l = paddle_q[0];
  assign paddle_r = paddle_q[1];
  assign score_l  = score_l_q;
  assign score_r  = score_r_q;
  assign state    = state_q;
  assign winner   = winner_q;
  assign point    = point_q;

endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine on a small 8x8 board: integer game model checked every cycle plus literal pins.
module tb_pong_engine;

  localparam int COLS = 8;
  localparam int ROWS = 8;
  localparam int PL   = 2;
  localparam int TD   = 2;
  localparam int BP   = 1;
  localparam int PP   = 1;
  localparam int SMAX = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, l_up = 1'b0, l_down = 1'b0, r_up = 1'b0, r_down = 1'b0;
  logic [2:0] ball_x, ball_y, paddle_l, paddle_r;
  logic [3:0] score_l, score_r;
  logic [1:0] state;
  logic       winner, point;

  pong_engine #(
    .COLS(COLS), .ROWS(ROWS), .PADDLE_LEN(PL), .TICK_DIV(TD),
    .BALL_PERIOD(BP), .PADDLE_PERIOD(PP), .SCORE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .l_up(l_up), .l_down(l_down), .r_up(r_up), .r_down(r_down),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_l(paddle_l), .paddle_r(paddle_r),
    .score_l(score_l), .score_r(score_r), .state(state), .winner(winner), .point(point)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Game model in plain integers: positions, signed velocities, tick counts since reset.
  int m_edges, m_ticks_b, m_ticks_p;
  int m_st, m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_win, m_point;

  task automatic model_reset();
    m_edges = 0; m_ticks_b = 0; m_ticks_p = 0;
    m_st = 0; m_bx = COLS / 2; m_by = ROWS / 2; m_dx = 1; m_dy = 1;
    m_pl = (ROWS - PL) / 2; m_pr = (ROWS - PL) / 2;
    m_sl = 0; m_sr = 0; m_win = 0; m_point = 0;
  endtask

  function automatic int move_paddle(int row, bit up, bit dn);
    if (up && !dn && row > 0) return row - 1;
    if (dn && !up && row < ROWS - PL) return row + 1;
    return row;
  endfunction

  task automatic model_step();
    bit is_tick, bstep, pstep, rup, rdn;
    int old_st, npl, npr, ny, scorer;
    is_tick = (m_edges % TD) == TD - 1;
    m_edges++;
    bstep = 0; pstep = 0;
    if (is_tick) begin
      bstep = (m_ticks_b % BP) == BP - 1;
      pstep = (m_ticks_p % PP) == PP - 1;
      m_ticks_b++; m_ticks_p++;
    end
    old_st = m_st;
`ifdef PONG_AI_EN
    rup = m_by < m_pr;
    rdn = m_by > m_pr + PL - 1;
`else
    rup = r_up;
    rdn = r_down;
`endif
    npl = m_pl; npr = m_pr;
    if (pstep && old_st != 3) begin
      npl = move_paddle(m_pl, l_up, l_down);
      npr = move_paddle(m_pr, rup, rdn);
    end
    m_point = 0;
    scorer = -1;
    case (old_st)
      0: if (start) begin m_st = 1; m_ticks_b = 0; end
      1: if (bstep) m_st = 2;
      2: if (bstep) begin
        if (m_by + m_dy < 0 || m_by + m_dy > ROWS - 1) m_dy = -m_dy;
        ny = m_by + m_dy;
        if (m_bx == 1 && m_dx < 0) begin
          if (ny >= m_pl && ny <= m_pl + PL - 1) begin m_dx = 1; m_bx = 2; end
          else scorer = 1;
        end else if (m_bx == COLS - 2 && m_dx > 0) begin
          if (ny >= m_pr && ny <= m_pr + PL - 1) begin m_dx = -1; m_bx = COLS - 3; end
          else scorer = 0;
        end else begin
          m_bx = m_bx + m_dx;
        end
        m_by = ny;
        if (scorer >= 0) begin
          m_point = 1;
          m_bx = COLS / 2; m_by = ROWS / 2;
          m_dx = (scorer == 1) ? -1 : 1;
          if (scorer == 1) m_sr++; else m_sl++;
          if ((scorer == 1 ? m_sr : m_sl) == SMAX) begin m_st = 3; m_win = scorer; end
          else begin m_st = 1; m_ticks_b = 0; end
        end
      end
      default: if (start) begin m_sl = 0; m_sr = 0; m_st = 1; m_ticks_b = 0; end
    endcase
    m_pl = npl; m_pr = npr;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic compare_model(input int cyc);
    n_cmp++;
    if (int'(ball_x) != m_bx || int'(ball_y) != m_by || int'(paddle_l) != m_pl ||
        int'(paddle_r) != m_pr || int'(score_l) != m_sl || int'(score_r) != m_sr ||
        int'(state) != m_st || int'(winner) != m_win || int'(point) != m_point) begin
      n_bad++;
      $display("FAIL model cyc %0d: got ball(%0d,%0d) pad(%0d,%0d) sc(%0d,%0d) st%0d win%0d pt%0d, want ball(%0d,%0d) pad(%0d,%0d) sc(%0d,%0d) st%0d win%0d pt%0d",
               cyc, ball_x, ball_y, paddle_l, paddle_r, score_l, score_r, state, winner, point,
               m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_st, m_win, m_point);
    end
  endtask

  int cyc = 0;

  // One clock: model advances on the edge, DUT is compared on the following falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare_model(cyc);
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " ball_x"}, int'(ball_x), 4);
    check({tag, " ball_y"}, int'(ball_y), 4);
    check({tag, " paddle_l"}, int'(paddle_l), 3);
    check({tag, " paddle_r"}, int'(paddle_r), 3);
    check({tag, " score_l"}, int'(score_l), 0);
    check({tag, " score_r"}, int'(score_r), 0);
    check({tag, " state"}, int'(state), 0);
    check({tag, " point"}, int'(point), 0);
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    $display("txn reset: ball(%0d,%0d) state %0d", ball_x, ball_y, state);
    #1 reset_n = 1'b1;

    // Paddle pins in IDLE: both buttons hold, up saturates at row 0.
    l_up = 1; l_down = 1;
    repeat (10) cycle();
    check("both held paddle_l", int'(paddle_l), 3);
    l_down = 0;
    repeat (10) cycle();
    check("up held paddle_l", int'(paddle_l), 0);
    $display("txn paddles: left %0d right %0d", paddle_l, paddle_r);
    l_up = 0;

    start = 1;
    cycle();
    start = 0;
    check("serve entry state", int'(state), 1);
    guard = 0;
    while (ball_x == 3'd4 && guard < 20) begin cycle(); guard++; end
    if (guard >= 20) timeout("first step");
    check("first step x", int'(ball_x), 5);
    check("first step y", int'(ball_y), 5);
    check("first step state", int'(state), 2);
    $display("txn first step: ball(%0d,%0d)", ball_x, ball_y);

`ifndef PONG_AI_EN
    guard = 0;
    do begin cycle(); guard++; end while (!point && guard < 40);
    if (!point) timeout("first miss");
    check("miss1 score_l", int'(score_l), 1);
    check("miss1 ball_x", int'(ball_x), 4);
    check("miss1 ball_y", int'(ball_y), 4);
    check("miss1 state", int'(state), 1);
    $display("txn miss1: score %0d-%0d state %0d", score_l, score_r, state);
    guard = 0;
    do begin cycle(); guard++; end while (!point && guard < 40);
    if (!point) timeout("second miss");
    check("miss2 score_l", int'(score_l), 2);
    check("miss2 state", int'(state), 3);
    check("miss2 winner", int'(winner), 0);
    $display("txn miss2: score %0d-%0d state %0d winner %0d", score_l, score_r, state, winner);
    repeat (4) cycle();
    check("over holds", int'(state), 3);
    start = 1;
    cycle();
    start = 0;
    check("restart state", int'(state), 1);
    check("restart score_l", int'(score_l), 0);
    $display("txn restart: state %0d score %0d-%0d", state, score_l, score_r);
`endif

    for (int i = 0; i < 3000; i++) begin
      l_up   = ($urandom_range(0, 3) == 0);
      l_down = ($urandom_range(0, 3) == 0);
      r_up   = ($urandom_range(0, 3) == 0);
      r_down = ($urandom_range(0, 3) == 0);
      start  = ($urandom_range(0, 15) == 0);
      if (i % 800 == 400) begin
        #1 reset_n = 1'b0;
        #1 check_reset_values("async reset");
        $display("txn async reset at cycle %0d", cyc);
        model_reset();
        @(negedge clk);
        #1 reset_n = 1'b1;
      end
      cycle();
    end
    start = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
